mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised N:1 operand-select multiplexer for the DSP datapath; successor to the fixed 4:1 selector.
- Generalised input count and width; optional select/input register and output register stages, each with clock enable and synchronous reset.
- Valid tag travels through the pipeline; sticky error flag for out-of-range selects.
- Sits between operand sources and the pre-adder, multiplier and post-adder stages.

Parameters:
- WIDTH, 48, data width of each input and of the output.
- NUM_IN, 8, number of inputs; legal range 2..2**SEL_W.
- SEL_W, 3, select width.
- SEL_REG, 1, 1 = register sel, in_bus and valid_in (stage 1); 0 = bypass.
- OUT_REG, 1, 1 = register mux result and valid (stage 2); 0 = bypass.

Ports:
- clk  input  1  clock, all registers rising-edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable for all pipeline registers.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select.
- valid_in  input  1  qualifies sel/in_bus this cycle.
- out  output  WIDTH  selected data.
- valid_out  output  1  out carries a valid result.
- sel_err  output  1  sticky: a valid select >= NUM_IN was seen.

Behaviour:
- Latency L = SEL_REG + OUT_REG cycles (0, 1 or 2), measured from valid_in/sel/in_bus to out/valid_out. Data, select and valid stay aligned at every stage.
- Stage 1 (SEL_REG=1): on a clk edge with ce=1, capture sel, in_bus and valid_in. With ce=0, hold.
- Mux: if the stage-1 select is < NUM_IN, the result is input[sel]. Otherwise the result is all zeros.
- Stage 2 (OUT_REG=1): on a clk edge with ce=1, capture the mux result and the stage-1 valid. With ce=0, hold.
- Bypassed stages are pure wires. With L=0, out and valid_out are combinational from the inputs.
- rst=1 at a clk edge clears every pipeline register (data, select, valid) to 0. rst has priority over ce.
- Reset values: out=0 when OUT_REG=1. valid_out=0 for L>=1. sel_err=0.
- For L=0, out and valid_out follow the inputs even during rst.
- Reset mid-flight discards all in-flight items; no valid_out is produced for them.
- sel_err is always a register, independent of SEL_REG/OUT_REG. It sets on the clk edge after a cycle in which the mux-stage valid=1 and the mux-stage sel >= NUM_IN.
  - It sets regardless of ce, provided the mux-stage value is live.
  - It clears only on rst. If set and rst coincide, rst wins.
- An out-of-range select with valid=0 sets no error and still outputs 0.
- Each cycle with ce=1 accepts a new item (throughput 1/cycle). There is no backpressure.
- ce=0 stalls the whole pipe; no items are lost or duplicated.
- NUM_IN = 2**SEL_W: no select is out of range and sel_err stays 0.
- Elaboration fails if NUM_IN < 2 or NUM_IN > 2**SEL_W.

Test Plan:
- Defaults (L=2), ce=1: input k = k+0x100, sel cycles 0..7, valid_in=1 -> out = 0x100..0x107 with valid_out=1, each 2 cycles after its input; sel_err=0.
- NUM_IN=5, SEL_W=3, sel=6, valid_in=1 -> out=0 after 2 cycles; sel_err=1 from the following edge and held until rst. The same with valid_in=0 -> sel_err stays 0.
- ce toggling 1,0,0,1 with items A=0xAAAA then B=0xBBBB -> out/valid_out hold during ce=0; A then B each appear exactly once, shifted by 2 stall cycles.
- rst=1 for one cycle while two items are in flight with ce=0 -> next cycle out=0, valid_out=0, sel_err=0; the in-flight items never emerge.
- Sweep SEL_REG/OUT_REG over {0,1}^2 with a sel=2 item -> output appears at latency 0/1/1/2; with L=0 it is the same-cycle combinational result.
- NUM_IN=4, SEL_W=2, random sel/data over 1000 cycles vs model -> exact match; sel_err never set.

Source files
------------

// File: rtl/mux_n_pipe.sv
// Parametrised N:1 operand-select mux with optional select/input and output register stages.
// A valid tag travels with the data; sel_err latches any valid out-of-range select.
module mux_n_pipe #(
   parameter int WIDTH   = 48,
   parameter int NUM_IN  = 8,
   parameter int SEL_W   = 3,
   parameter int SEL_REG = 1,
   parameter int OUT_REG = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    valid_in,
   output logic [WIDTH-1:0]        out,
   output logic                    valid_out,
   output logic                    sel_err
);

   localparam logic [31:0] NUM_IN_U = 32'(NUM_IN);

   if ((NUM_IN < 2) || (NUM_IN > (2 ** SEL_W))) begin : g_bad_num_in
      $error("mux_n_pipe: NUM_IN must lie in 2..2**SEL_W");
   end

   // OR-of-AND selection: an out-of-range select matches no input and yields zero
   function automatic logic [WIDTH-1:0] mux_pick(
      input logic [SEL_W-1:0]        s,
      input logic [NUM_IN*WIDTH-1:0] d
   );
      logic [WIDTH-1:0] acc;
      acc = {WIDTH{1'b0}};
      for (int k = 0; k < NUM_IN; k++) begin
         acc = acc | ({WIDTH{s == SEL_W'(k)}} & d[k*WIDTH +: WIDTH]);
      end
      return acc;
   endfunction

   logic [SEL_W-1:0]        sel_m_s;
   logic [NUM_IN*WIDTH-1:0] in_m_s;
   logic                    valid_m_s;
   logic [WIDTH-1:0]        mux_s;
   logic                    range_err_s;
   logic                    sel_err_r;

   if (SEL_REG != 0) begin : g_stage1
      logic [SEL_W-1:0]        sel_r;
      logic [NUM_IN*WIDTH-1:0] in_r;
      logic                    valid_r;

      // stage 1: capture select, operands and valid tag together
      always_ff @(posedge clk) begin
         if (rst) begin
            sel_r   <= {SEL_W{1'b0}};
            in_r    <= {(NUM_IN*WIDTH){1'b0}};
            valid_r <= 1'b0;
         end else if (ce) begin
            sel_r   <= sel;
            in_r    <= in_bus;
            valid_r <= valid_in;
         end else begin
            sel_r   <= sel_r;
            in_r    <= in_r;
            valid_r <= valid_r;
         end
      end

      assign sel_m_s   = sel_r;
      assign in_m_s    = in_r;
      assign valid_m_s = valid_r;
   end else begin : g_stage1_bypass
      assign sel_m_s   = sel;
      assign in_m_s    = in_bus;
      assign valid_m_s = valid_in;
   end

   // select decode and range check on the mux-stage values
   always_comb begin
      mux_s       = mux_pick(sel_m_s, in_m_s);
      range_err_s = valid_m_s && (32'(sel_m_s) >= NUM_IN_U);
   end

   if (OUT_REG != 0) begin : g_stage2
      logic [WIDTH-1:0] out_r;
      logic             valid_r;

      // stage 2: register mux result with its valid tag
      always_ff @(posedge clk) begin
         if (rst) begin
            out_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
         end else if (ce) begin
            out_r   <= mux_s;
            valid_r <= valid_m_s;
         end else begin
            out_r   <= out_r;
            valid_r <= valid_r;
         end
      end

      assign out       = out_r;
      assign valid_out = valid_r;
   end else begin : g_stage2_bypass
      assign out       = mux_s;
      assign valid_out = valid_m_s;
   end

   // sticky error: ignores ce so a stalled out-of-range item still flags; only rst clears
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_r <= 1'b0;
      end else if (range_err_s) begin
         sel_err_r <= 1'b1;
      end else begin
         sel_err_r <= sel_err_r;
      end
   end

   assign sel_err = sel_err_r;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and model-based checks of mux_n_pipe across several parameter sets.
// All instances share one stimulus bus; each scenario checks the instances it concerns.
module tb_mux_n_pipe;

   logic         clk = 1'b0;
   logic         rst;
   logic         ce;
   logic         vin;
   logic [2:0]   sel;
   logic [383:0] in_bus;

   logic [47:0] out_def, out_n5, out_n4, out_l0, out_l1a, out_l1b;
   logic        vo_def, vo_n5, vo_n4, vo_l0, vo_l1a, vo_l1b;
   logic        err_def, err_n5, err_n4, err_l0, err_l1a, err_l1b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_n_pipe u_def (
      .clk(clk), .rst(rst), .ce(ce), .in_bus(in_bus), .sel(sel), .valid_in(vin),
      .out(out_def), .valid_out(vo_def), .sel_err(err_def));

   mux_n_pipe #(.NUM_IN(5)) u_n5 (
      .clk(clk), .rst(rst), .ce(ce), .in_bus(in_bus[239:0]), .sel(sel), .valid_in(vin),
      .out(out_n5), .valid_out(vo_n5), .sel_err(err_n5));

   mux_n_pipe #(.NUM_IN(4), .SEL_W(2)) u_n4 (
      .clk(clk), .rst(rst), .ce(ce), .in_bus(in_bus[191:0]), .sel(sel[1:0]), .valid_in(vin),
      .out(out_n4), .valid_out(vo_n4), .sel_err(err_n4));

   mux_n_pipe #(.SEL_REG(0), .OUT_REG(0)) u_l0 (
      .clk(clk), .rst(rst), .ce(ce), .in_bus(in_bus), .sel(sel), .valid_in(vin),
      .out(out_l0), .valid_out(vo_l0), .sel_err(err_l0));

   mux_n_pipe #(.SEL_REG(1), .OUT_REG(0)) u_l1a (
      .clk(clk), .rst(rst), .ce(ce), .in_bus(in_bus), .sel(sel), .valid_in(vin),
      .out(out_l1a), .valid_out(vo_l1a), .sel_err(err_l1a));

   mux_n_pipe #(.SEL_REG(0), .OUT_REG(1)) u_l1b (
      .clk(clk), .rst(rst), .ce(ce), .in_bus(in_bus), .sel(sel), .valid_in(vin),
      .out(out_l1b), .valid_out(vo_l1b), .sel_err(err_l1b));

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input int k, input logic [47:0] v);
      in_bus[k*48 +: 48] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      ce = 1'b1; vin = 1'b1; sel = 3'd1; in_bus = {384{1'b1}};
      do_reset();
      vin = 1'b0;
      total++;
      if ({out_def, vo_def, err_def} !== 50'd0) begin
         bad++; $display("FAIL reset_def got out=%h v=%b err=%b want 0/0/0", out_def, vo_def, err_def);
      end
      total++;
      if ({out_l1b, vo_l1b, vo_l1a, err_n5, err_n4, err_l0, err_l1a, err_l1b} !== 55'd0) begin
         bad++; $display("FAIL reset_variants got l1b_out=%h l1b_v=%b l1a_v=%b errs=%b%b%b%b%b want zeros",
                         out_l1b, vo_l1b, vo_l1a, err_n5, err_n4, err_l0, err_l1a, err_l1b);
      end
   endtask

   task automatic test_default();
      logic [47:0] exp;
      for (int k = 0; k < 8; k++) set_in(k, 48'h100 + 48'(k));
      for (int i = 0; i < 10; i++) begin
         vin = (i < 8) ? 1'b1 : 1'b0;
         sel = (i < 8) ? 3'(i) : 3'd0;
         tick();
         exp = 48'h100 + 48'(i - 1);
         total++;
         if ((i >= 1) && (i <= 8)) begin
            if ((out_def !== exp) || (vo_def !== 1'b1)) begin
               bad++; $display("FAIL default_item i=%0d got out=%h v=%b want out=%h v=1", i, out_def, vo_def, exp);
            end
         end else if (vo_def !== 1'b0) begin
            bad++; $display("FAIL default_idle i=%0d got v=%b want 0", i, vo_def);
         end
      end
      total++;
      if (err_def !== 1'b0) begin
         bad++; $display("FAIL default_err got %b want 0", err_def);
      end
   endtask

   task automatic test_sel_range();
      for (int k = 0; k < 8; k++) set_in(k, 48'h5000 + 48'(k));
      do_reset();
      sel = 3'd6; vin = 1'b1;
      tick();
      vin = 1'b0; sel = 3'd0;
      total++;
      if (err_n5 !== 1'b0) begin
         bad++; $display("FAIL range_err_early got %b want 0", err_n5);
      end
      tick();
      total++;
      if ((out_n5 !== 48'd0) || (vo_n5 !== 1'b1) || (err_n5 !== 1'b1)) begin
         bad++; $display("FAIL range_item got out=%h v=%b err=%b want 0/1/1", out_n5, vo_n5, err_n5);
      end
      tick(); tick();
      total++;
      if ((err_n5 !== 1'b1) || (err_def !== 1'b0)) begin
         bad++; $display("FAIL range_sticky got n5=%b def=%b want 1/0", err_n5, err_def);
      end
      do_reset();
      total++;
      if (err_n5 !== 1'b0) begin
         bad++; $display("FAIL range_clear got %b want 0", err_n5);
      end
      sel = 3'd6; vin = 1'b0;
      tick(); tick(); tick();
      total++;
      if ((err_n5 !== 1'b0) || (out_n5 !== 48'd0) || (vo_n5 !== 1'b0)) begin
         bad++; $display("FAIL range_invalid got err=%b out=%h v=%b want 0/0/0", err_n5, out_n5, vo_n5);
      end
      sel = 3'd0;
   endtask

   task automatic test_stall();
      logic [47:0] exp_out [6];
      logic        exp_v   [6];
      logic        ce_seq  [6];
      exp_out = '{48'h0, 48'h0, 48'h0, 48'hAAAA, 48'hBBBB, 48'h0};
      exp_v   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      ce_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      sel = 3'd2;
      for (int i = 0; i < 6; i++) begin
         ce  = ce_seq[i];
         vin = (i < 4) ? 1'b1 : 1'b0;
         set_in(2, (i == 0) ? 48'hAAAA : 48'hBBBB);
         tick();
         total++;
         if ((vo_def !== exp_v[i]) || (exp_v[i] && (out_def !== exp_out[i]))) begin
            bad++; $display("FAIL stall_step i=%0d got out=%h v=%b want out=%h v=%b",
                            i, out_def, vo_def, exp_out[i], exp_v[i]);
         end
      end
      ce = 1'b1;
   endtask

   task automatic test_flush();
      logic seen;
      do_reset();
      sel = 3'd3; vin = 1'b1; set_in(3, 48'h1111);
      tick();
      set_in(3, 48'h2222);
      tick();
      ce = 1'b0; vin = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ((out_def !== 48'd0) || (vo_def !== 1'b0) || (err_def !== 1'b0)) begin
         bad++; $display("FAIL flush_clear got out=%h v=%b err=%b want 0/0/0", out_def, vo_def, err_def);
      end
      ce = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen = seen | vo_def;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL flush_ghost got valid_out=1 want 0");
      end
   endtask

   task automatic test_latency();
      logic [47:0] v2;
      logic [47:0] v0;
      v2 = 48'h1234_5678_9ABC;
      v0 = 48'h0F0F_0000_7777;
      set_in(2, v2); set_in(0, v0);
      sel = 3'd2; vin = 1'b1; rst = 1'b1;
      #1;
      total++;
      if ((out_l0 !== v2) || (vo_l0 !== 1'b1)) begin
         bad++; $display("FAIL lat0_in_rst got out=%h v=%b want out=%h v=1", out_l0, vo_l0, v2);
      end
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ((out_l0 !== v2) || (vo_l0 !== 1'b1)) begin
         bad++; $display("FAIL lat0 got out=%h v=%b want out=%h v=1", out_l0, vo_l0, v2);
      end
      tick();
      sel = 3'd0; vin = 1'b0;
      #1;
      total++;
      if ((out_l1a !== v2) || (vo_l1a !== 1'b1) || (out_l1b !== v2) || (vo_l1b !== 1'b1) || (vo_def !== 1'b0)) begin
         bad++; $display("FAIL lat1 got l1a=%h/%b l1b=%h/%b def_v=%b want %h/1 %h/1 0",
                         out_l1a, vo_l1a, out_l1b, vo_l1b, vo_def, v2, v2);
      end
      total++;
      if ((out_l0 !== v0) || (vo_l0 !== 1'b0)) begin
         bad++; $display("FAIL lat0_next got out=%h v=%b want out=%h v=0", out_l0, vo_l0, v0);
      end
      tick();
      total++;
      if ((out_def !== v2) || (vo_def !== 1'b1) || (vo_l1a !== 1'b0) || (vo_l1b !== 1'b0) || (out_l1a !== v0)) begin
         bad++; $display("FAIL lat2 got def=%h/%b l1a=%h/%b l1b_v=%b want %h/1 %h/0 0",
                         out_def, vo_def, out_l1a, vo_l1a, vo_l1b, v2, v0);
      end
   endtask

   task automatic test_random();
      logic [47:0] prev_out;
      logic        prev_v;
      logic [47:0] cur_out;
      logic        cur_v;
      logic [1:0]  s;
      do_reset();
      ce = 1'b1;
      prev_out = 48'd0;
      prev_v   = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 4; k++) set_in(k, {16'($urandom), $urandom});
         s     = 2'($urandom_range(3, 0));
         sel   = {1'b0, s};
         vin   = 1'($urandom_range(1, 0));
         cur_out = in_bus[32'(s)*48 +: 48];
         cur_v   = vin;
         tick();
         total++;
         if ((out_n4 !== prev_out) || (vo_n4 !== prev_v)) begin
            bad++; $display("FAIL random_n4 i=%0d got out=%h v=%b want out=%h v=%b",
                            i, out_n4, vo_n4, prev_out, prev_v);
         end
         prev_out = cur_out;
         prev_v   = cur_v;
      end
      total++;
      if (err_n4 !== 1'b0) begin
         bad++; $display("FAIL random_err got %b want 0", err_n4);
      end
   endtask

   initial begin
      rst = 1'b0; ce = 1'b1; vin = 1'b0; sel = 3'd0; in_bus = '0;
      #1;
      test_reset();
      test_default();
      test_sel_range();
      test_stall();
      test_flush();
      test_latency();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
